// File: rtl/grid_game_pkg.sv
// Shared encodings for the N x N, K-in-a-row board engine.
// Contains only constants and types; no logic.
package grid_game_pkg;

    localparam logic [2:0] DIR_IDLE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_RIGHT = 3'd3;
    localparam logic [2:0] DIR_LEFT  = 3'd4;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_P1    = 2'd1;
    localparam logic [1:0] CELL_P2    = 2'd2;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    localparam logic [1:0] STEP_H = 2'd0;
    localparam logic [1:0] STEP_V = 2'd1;
    localparam logic [1:0] STEP_D = 2'd2;
    localparam logic [1:0] STEP_A = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLACE,
        ST_CHECK,
        ST_RESOLVE,
        ST_OVER
    } state_t;

endpackage

// File: rtl/run_length_probe.sv
// Run length through one cell along one line direction, counting both senses.
// Purely combinational; no flow control.
// Each side probes at most WIN_LEN-1 cells and stops at the board edge.
module run_length_probe
    import grid_game_pkg::*;
#(
    parameter int N = 3,
    parameter int WIN_LEN = 3,
    localparam int IDXW = $clog2(N*N),
    localparam int RUNW = $clog2(2*WIN_LEN)
) (
    input  logic [2*N*N-1:0] board_i,
    input  logic [IDXW-1:0]  place_idx_i,
    input  logic [1:0]       player_i,
    input  logic [1:0]       sel_i,
    output logic [RUNW-1:0]  run_o
);

    logic [1:0] cells [N*N];

    always_comb begin
        for (int i = 0; i < N*N; i++) begin
            cells[i] = board_i[2*i +: 2];
        end
    end

    always_comb begin
        int row, col, dr, dc, r, c, idx, cnt;
        logic alive;
        row   = int'(place_idx_i) / N;
        col   = int'(place_idx_i) % N;
        r     = 0;
        c     = 0;
        idx   = 0;
        cnt   = 1;
        alive = 1'b1;
        case (sel_i)
            STEP_V:  begin dr = 1; dc = 0;  end
            STEP_D:  begin dr = 1; dc = 1;  end
            STEP_A:  begin dr = 1; dc = -1; end
            default: begin dr = 0; dc = 1;  end
        endcase
        // s=0 walks forward along (dr,dc), s=1 walks backward
        for (int s = 0; s < 2; s++) begin
            alive = 1'b1;
            for (int k = 1; k < WIN_LEN; k++) begin
                r = (s == 0) ? row + k*dr : row - k*dr;
                c = (s == 0) ? col + k*dc : col - k*dc;
                idx = (r >= 0 && r < N && c >= 0 && c < N) ? r*N + c : -1;
                if (alive && idx >= 0 && cells[idx[IDXW-1:0]] == player_i) begin
                    cnt = cnt + 1;
                end else begin
                    alive = 1'b0;
                end
            end
        end
        run_o = cnt[RUNW-1:0];
    end

endmodule

// File: rtl/grid_game_core.sv
// Two-player N x N board engine: cursor, placement, turn, win/draw check.
// Move latency 7 cycles from confirm edge to winner/turn update; busy meanwhile.
// Confirm edges while busy or game over are dropped; GRID_CURSOR_WRAP_EN makes the cursor wrap.
module grid_game_core
    import grid_game_pkg::*;
#(
    parameter int N = 3,
    parameter int WIN_LEN = 3,
    localparam int IDXW = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [2:0]        dir,
    input  logic              confirm,
    input  logic              restart,
    output logic [IDXW-1:0]   cursor,
    output logic [2*N*N-1:0]  board,
    output logic              turn,
    output logic              busy,
    output logic              illegal,
    output logic [1:0]        winner,
    output logic              game_over
);

    localparam int CNTW = $clog2(N*N+1);
    localparam int RUNW = $clog2(2*WIN_LEN);
`ifdef GRID_CURSOR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    state_t          state_q;
    logic [IDXW-1:0] cursor_q, cursor_d, place_idx_q;
    logic [1:0]      cells_q [N*N];
    logic            turn_q, illegal_q, confirm_q, win_q;
    logic [1:0]      winner_q, d_q, player;
    logic [CNTW-1:0] move_cnt_q;
    logic [RUNW-1:0] run_len;

    always_comb begin
        int row, col;
        row = int'(cursor_q) / N;
        col = int'(cursor_q) % N;
        case (dir)
            DIR_UP:    if (row > 0)   row = row - 1; else if (WRAP_EN) row = N - 1;
            DIR_DOWN:  if (row < N-1) row = row + 1; else if (WRAP_EN) row = 0;
            DIR_RIGHT: if (col < N-1) col = col + 1; else if (WRAP_EN) col = 0;
            DIR_LEFT:  if (col > 0)   col = col - 1; else if (WRAP_EN) col = N - 1;
            default: ;
        endcase
        cursor_d = IDXW'(row*N + col);
    end

    always_comb begin
        for (int i = 0; i < N*N; i++) begin
            board[2*i +: 2] = cells_q[i];
        end
    end

    assign player = turn_q ? CELL_P2 : CELL_P1;

    run_length_probe #(.N(N), .WIN_LEN(WIN_LEN)) u_probe (
        .board_i     (board),
        .place_idx_i (place_idx_q),
        .player_i    (player),
        .sel_i       (d_q),
        .run_o       (run_len)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cursor_q    <= '0;
            place_idx_q <= '0;
            for (int i = 0; i < N*N; i++) cells_q[i] <= CELL_EMPTY;
            turn_q      <= 1'b0;
            illegal_q   <= 1'b0;
            confirm_q   <= 1'b0;
            win_q       <= 1'b0;
            winner_q    <= WIN_NONE;
            d_q         <= '0;
            move_cnt_q  <= '0;
        end else begin
            confirm_q <= confirm;
            illegal_q <= 1'b0;
            if (restart) begin
                state_q    <= ST_IDLE;
                cursor_q   <= '0;
                for (int i = 0; i < N*N; i++) cells_q[i] <= CELL_EMPTY;
                turn_q     <= 1'b0;
                win_q      <= 1'b0;
                winner_q   <= WIN_NONE;
                d_q        <= '0;
                move_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (confirm && !confirm_q) begin
                            place_idx_q <= cursor_q;
                            // Flag now so the pulse lines up with the PLACE cycle
                            illegal_q   <= (cells_q[cursor_q] != CELL_EMPTY);
                            state_q     <= ST_PLACE;
                        end else begin
                            cursor_q <= cursor_d;
                        end
                    end
                    ST_PLACE: begin
                        if (cells_q[place_idx_q] == CELL_EMPTY) begin
                            cells_q[place_idx_q] <= player;
                            move_cnt_q <= move_cnt_q + 1'b1;
                            d_q        <= '0;
                            win_q      <= 1'b0;
                            state_q    <= ST_CHECK;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_CHECK: begin
                        if (int'(run_len) >= WIN_LEN) win_q <= 1'b1;
                        if (d_q == STEP_A) state_q <= ST_RESOLVE;
                        else d_q <= d_q + 1'b1;
                    end
                    ST_RESOLVE: begin
                        if (win_q) begin
                            winner_q <= turn_q ? WIN_P2 : WIN_P1;
                            state_q  <= ST_OVER;
                        end else if (move_cnt_q == CNTW'(N*N)) begin
                            winner_q <= WIN_DRAW;
                            state_q  <= ST_OVER;
                        end else begin
                            turn_q  <= ~turn_q;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_OVER: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cursor    = cursor_q;
    assign turn      = turn_q;
    assign illegal   = illegal_q;
    assign winner    = winner_q;
    assign game_over = (winner_q != WIN_NONE);
    assign busy      = (state_q == ST_PLACE) || (state_q == ST_CHECK) || (state_q == ST_RESOLVE);

endmodule
